vga_write_sched: RTL

VGA_WRITE_SCHED -- requirements
Module: vga_write_sched

---
 rtl/vga_write_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vga_write_sched.sv
// Write scheduler for the VGA frame buffers: merges CPU writes with a background
// screen-fill engine onto one registered write port. A starvation limit stops the CPU from blocking the fill forever.
module vga_write_sched #(
    parameter int TEXT_DEPTH   = 4800,
    parameter int GRAPH_DEPTH  = 307200,
    parameter int STARVE_LIMIT = 4,
    parameter bit BLANK_ONLY   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [1:0]  cpu_sel,
    input  logic [18:0] cpu_addr,
    input  logic [31:0] cpu_data,
    output logic        cpu_ack,
    input  logic        fill_start,
    input  logic        fill_mode,
    input  logic [31:0] fill_data,
    input  logic        fill_abort,
    input  logic        vga_busy,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        we_text,
    output logic        we_graph,
    output logic        we_cursor,
    output logic        we_reg,
    output logic [12:0] text_addr,
    output logic [18:0] graph_addr,
    output logic [31:0] data_out
);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [18:0]   TEXT_LAST  = 19'(TEXT_DEPTH - 1);
    localparam logic [18:0]   GRAPH_LAST = 19'(GRAPH_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_mode;
    logic [31:0]     r_fill_data;
    logic [18:0]     r_cnt;
    logic [SW-1:0]   r_starve;
    logic            r_cpu_ack;
    logic            r_fill_busy;
    logic            r_fill_done;
    logic            r_we_text;
    logic            r_we_graph;
    logic            r_we_cursor;
    logic            r_we_reg;
    logic [12:0]     r_text_addr;
    logic [18:0]     r_graph_addr;
    logic [31:0]     r_data;

    logic            w_fill_elig;
    logic            w_fill_gnt;
    logic            w_cpu_gnt;
    logic            w_fill_last;

    // An acknowledged request that is still held owns its turnaround slot, so the
    // fill only steals that slot once the starve counter has reached its limit.
    always_comb begin
        w_fill_elig = (r_state == FILL) && !fill_abort && (!BLANK_ONLY || !vga_busy);
        w_fill_gnt  = w_fill_elig && (!cpu_req || (r_starve == STARVE_MAX));
        w_cpu_gnt   = cpu_req && !r_cpu_ack && !w_fill_gnt;
        w_fill_last = (r_cnt == (r_mode ? GRAPH_LAST : TEXT_LAST));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (fill_start) w_state_nxt = FILL;
            FILL: begin
                if (fill_abort)                     w_state_nxt = IDLE;
                else if (w_fill_gnt && w_fill_last) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mode      <= 1'b0;
            r_fill_data <= '0;
            r_cnt       <= '0;
            r_starve    <= '0;
            r_fill_busy <= 1'b0;
            r_fill_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill_busy <= (w_state_nxt != IDLE);
            r_fill_done <= (r_state == DONE);
            if ((r_state == IDLE) && fill_start) begin
                r_mode      <= fill_mode;
                r_fill_data <= fill_data;
            end
            if (r_state == IDLE)
                r_cnt <= '0;
            else if (w_fill_gnt)
                r_cnt <= r_cnt + 19'd1;
            if ((r_state != FILL) || w_fill_gnt)
                r_starve <= '0;
            else if (w_cpu_gnt && w_fill_elig && (r_starve != STARVE_MAX))
                r_starve <= r_starve + SW'(1);
        end
    end

    // Write port: strobes are single-cycle, addresses and data hold between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cpu_ack    <= 1'b0;
            r_we_text    <= 1'b0;
            r_we_graph   <= 1'b0;
            r_we_cursor  <= 1'b0;
            r_we_reg     <= 1'b0;
            r_text_addr  <= '0;
            r_graph_addr <= '0;
            r_data       <= '0;
        end else begin
            r_cpu_ack   <= w_cpu_gnt;
            r_we_text   <= 1'b0;
            r_we_graph  <= 1'b0;
            r_we_cursor <= 1'b0;
            r_we_reg    <= 1'b0;
            if (w_cpu_gnt) begin
                r_data <= cpu_data;
                case (cpu_sel)
                    2'b00: begin
                        r_we_text   <= 1'b1;
                        r_text_addr <= cpu_addr[12:0];
                    end
                    2'b01: begin
                        r_we_graph   <= 1'b1;
                        r_graph_addr <= cpu_addr;
                    end
                    2'b10:   r_we_cursor <= 1'b1;
                    default: r_we_reg    <= 1'b1;
                endcase
            end else if (w_fill_gnt) begin
                if (r_mode) begin
                    r_we_graph   <= 1'b1;
                    r_graph_addr <= r_cnt;
                    r_data       <= {20'b0, r_fill_data[11:0]};
                end else begin
                    r_we_text   <= 1'b1;
                    r_text_addr <= r_cnt[12:0];
                    r_data      <= r_fill_data;
                end
            end
        end
    end

    assign cpu_ack    = r_cpu_ack;
    assign fill_busy  = r_fill_busy;
    assign fill_done  = r_fill_done;
    assign we_text    = r_we_text;
    assign we_graph   = r_we_graph;
    assign we_cursor  = r_we_cursor;
    assign we_reg     = r_we_reg;
    assign text_addr  = r_text_addr;
    assign graph_addr = r_graph_addr;
    assign data_out   = r_data;

endmodule
